ws2812_strip_ctrl: RTL

//  Frame sequencer for a WS2812 single-pixel serializer. On start it walks NUM_PIXELS entries of
//  an external pixel RAM and loads each entry into the serializer with a one-cycle write-enable

---
 rtl/ws2812_pkg.sv | 25 ++
 rtl/ws2812_ack_wait.sv | 38 +++
 rtl/ws2812_strip_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared state encoding and pixel word layout for the WS2812 strip sequencer
package ws2812_pkg;

    localparam int PIX_W = 24;
    localparam int COL_W = 8;

    // Colour field offsets inside the {green, red, blue} pixel word.
    localparam int G_LSB = 16;
    localparam int R_LSB = 8;
    localparam int B_LSB = 0;

    typedef logic [3:0] state_t;

    localparam state_t IDLE = 4'd0;
    localparam state_t RD   = 4'd1;
    localparam state_t CAP  = 4'd2;
    localparam state_t LOAD = 4'd3;
    localparam state_t WHI  = 4'd4;
    localparam state_t WLO  = 4'd5;
    localparam state_t LAT  = 4'd6;
    localparam state_t RHI  = 4'd7;
    localparam state_t RLO  = 4'd8;
    localparam state_t DONE = 4'd9;

endpackage

// File: rtl/ws2812_ack_wait.sv
// rtl/ws2812_ack_wait.sv - serializer handshake: bounded wait for ser_busy to rise, then wait for it to fall
module ws2812_ack_wait
    import ws2812_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    input  logic wait_hi,
    input  logic wait_lo,
    input  logic ser_busy,
    output logic rose,
    output logic fell,
    output logic timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Counts cycles elapsed since the load/latch pulse; idle in every other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (pulse || wait_hi) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    assign rose    = wait_hi & ser_busy;
    assign fell    = wait_lo & ~ser_busy;
    assign timeout = wait_hi & ~ser_busy & (cnt >= LIMIT);

endmodule

// File: rtl/ws2812_strip_ctrl.sv
// rtl/ws2812_strip_ctrl.sv - WS2812 frame sequencer: pixel RAM walk, serializer loads and latch reset
// Optional auto-refresh start generator is built when WS2812_AUTO_REFRESH_EN is defined.
module ws2812_strip_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_PIXELS    = 60,
    parameter int ADDR_W        = 6,
    parameter int ACK_TIMEOUT   = 15,
    parameter int REFRESH_TICKS = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [COL_W-1:0]  ser_green,
    output logic [COL_W-1:0]  ser_red,
    output logic [COL_W-1:0]  ser_blue,
    output logic              ser_we,
    output logic              ser_rst,
    input  logic              ser_busy
);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] idx;
    logic              last;
    logic              start_go;
    logic              pulse;
    logic              wait_hi;
    logic              wait_lo;
    logic              rose;
    logic              fell;
    logic              timeout;

    assign last     = (idx == ADDR_W'(NUM_PIXELS - 1));
    assign mem_addr = idx;

`ifdef WS2812_AUTO_REFRESH_EN
    localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;

    logic [RW-1:0] ref_cnt;
    logic          tick;
    logic          pend;

    assign tick = (ref_cnt == RW'(REFRESH_TICKS - 1));

    // Free-running period counter; a tick seen mid-frame is remembered once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            pend    <= 1'b0;
        end else begin
            ref_cnt <= tick ? '0 : ref_cnt + RW'(1);
            if (state == IDLE) begin
                pend <= 1'b0;
            end else if (tick) begin
                pend <= 1'b1;
            end
        end
    end

    assign start_go = start | tick | pend;
`else
    logic unused_refresh;
    assign unused_refresh = (REFRESH_TICKS != 0);
    assign start_go       = start;
`endif

    ws2812_ack_wait #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_wait (
        .clk      (clk),
        .rst      (rst),
        .pulse    (pulse),
        .wait_hi  (wait_hi),
        .wait_lo  (wait_lo),
        .ser_busy (ser_busy),
        .rose     (rose),
        .fell     (fell),
        .timeout  (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_go) state_nx = RD;
            RD:   state_nx = CAP;
            CAP:  state_nx = LOAD;
            LOAD: state_nx = WHI;
            WHI: begin
                if (rose) begin
                    state_nx = WLO;
                end else if (timeout) begin
                    state_nx = DONE;
                end
            end
            WLO:  if (fell) state_nx = last ? LAT : RD;
            LAT:  state_nx = RHI;
            RHI: begin
                if (rose) begin
                    state_nx = RLO;
                end else if (timeout) begin
                    state_nx = DONE;
                end
            end
            RLO:  if (fell) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = 1'b0;
        mem_rd  = 1'b0;
        ser_we  = 1'b0;
        ser_rst = 1'b0;
        pulse   = 1'b0;
        wait_hi = 1'b0;
        wait_lo = 1'b0;
        case (state)
            RD:   mem_rd  = 1'b1;
            LOAD: begin
                ser_we = 1'b1;
                pulse  = 1'b1;
            end
            LAT: begin
                ser_rst = 1'b1;
                pulse   = 1'b1;
            end
            WHI, RHI: wait_hi = 1'b1;
            WLO, RLO: wait_lo = 1'b1;
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            ser_green <= '0;
            ser_red   <= '0;
            ser_blue  <= '0;
            err       <= 1'b0;
        end else begin
            if (state == CAP) begin
                ser_green <= mem_data[G_LSB +: COL_W];
                ser_red   <= mem_data[R_LSB +: COL_W];
                ser_blue  <= mem_data[B_LSB +: COL_W];
            end
            // The index only returns to zero through DONE, including after an abort.
            if (state == WLO && fell && !last) begin
                idx <= idx + ADDR_W'(1);
            end else if (state == DONE) begin
                idx <= '0;
            end
            if (state == IDLE && start_go) begin
                err <= 1'b0;
            end else if (timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule
